shift_rows_stream: RTL and testbench

- Streaming, parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. Supports block widths Nb = 4, 6 or 8 columns and per-transfer selection of forward or inverse direction.
- Sits between SubBytes and MixColumns in the iterative round pipeline. Uses a valid/ready handshake on both sides.
- Output is registered with a one-entry skid buffer, so it sustains 1 state per cycle under backpressure.

---
 rtl/shift_rows_stream.sv | 63 ++++++
 tb/tb_shift_rows_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: streaming AES ShiftRows/InvShiftRows stage, registered output plus one-entry skid buffer
module shift_rows_stream #(
  parameter int Nb = 4,
  parameter int W  = 32*Nb
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
  input  logic [W-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_inverse,
  output logic [W-1:0] out_state
);
  logic [W-1:0] shifted, skid_state;
  logic         skid_valid, skid_inverse, acc;
  if (!(Nb == 4 || Nb == 6 || Nb == 8)) begin : g_bad_nb
    $error("shift_rows_stream: Nb must be 4, 6 or 8");
  end
  if (W != 32*Nb) begin : g_bad_w
    $error("shift_rows_stream: W is derived from Nb and must not be overridden");
  end
  // Nb=8 uses Rijndael's wider offsets (0,1,3,4)
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int S = r == 0 ? 0 : r == 1 ? 1 : r == 2 ? (Nb == 8 ? 3 : 2) : (Nb == 8 ? 4 : 3);
    for (genvar c = 0; c < Nb; c++) begin : g_col
      assign shifted[W-1-8*(4*c+r) -: 8] = in_inverse ? in_state[W-1-8*(4*((c+Nb-S)%Nb)+r) -: 8]
                                                      : in_state[W-1-8*(4*((c+S)%Nb)+r) -: 8];
    end
  end
  assign in_ready = !skid_valid && !rst;
  assign acc      = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_state    <= '0;
      out_inverse  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_state   <= '0;
      skid_inverse <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_state   <= skid_state;
        out_inverse <= skid_inverse;
        skid_valid  <= 1'b0;
      end
    end else if (acc) begin
      if (!out_valid || out_ready) begin
        out_valid   <= 1'b1;
        out_state   <= shifted;
        out_inverse <= in_inverse;
      end else begin
        skid_valid   <= 1'b1;
        skid_state   <= shifted;
        skid_inverse <= in_inverse;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: directed and randomized checks of shift_rows_stream for Nb = 4, 6 and 8
module tb_shift_rows_stream;
  logic clk = 1'b0;
  logic rst;
  logic iv4, ir4, ii4, ov4, or4, oi4;
  logic [127:0] is4, os4;
  logic iv6, ir6, ii6, ov6, or6, oi6;
  logic [191:0] is6, os6;
  logic iv8, ir8, ii8, ov8, or8, oi8;
  logic [255:0] is8, os8;
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] AES_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] AES_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [255:0] SEQ32   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  shift_rows_stream #(.Nb(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_inverse(ii4),
    .in_state(is4), .out_valid(ov4), .out_ready(or4), .out_inverse(oi4), .out_state(os4));
  shift_rows_stream #(.Nb(6)) dut6 (.clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .in_inverse(ii6),
    .in_state(is6), .out_valid(ov6), .out_ready(or6), .out_inverse(oi6), .out_state(os6));
  shift_rows_stream #(.Nb(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_inverse(ii8),
    .in_state(is8), .out_valid(ov8), .out_ready(or8), .out_inverse(oi8), .out_state(os8));

  // Reference: forward gathers out[r][c] = in[r][c+sh], inverse scatters out[r][c+sh] = in[r][c]
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] s, input logic inv);
    logic [255:0] o;
    int w, sh, dc;
    o = '0;
    w = 32*nb;
    for (int r = 0; r < 4; r++) begin
      sh = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? ((nb == 8) ? 3 : 2) : ((nb == 8) ? 4 : 3);
      for (int c = 0; c < nb; c++) begin
        dc = (c + sh) % nb;
        if (inv) o[w-1-8*(4*dc+r) -: 8] = s[w-1-8*(4*c+r) -: 8];
        else     o[w-1-8*(4*c+r) -: 8] = s[w-1-8*(4*dc+r) -: 8];
      end
    end
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", ov4); end
    checks++; if (os4 !== '0) begin failures++; $display("FAIL reset_out_state got=%h want=0", os4); end
    checks++; if (oi4 !== 1'b0) begin failures++; $display("FAIL reset_out_inverse got=%0b want=0", oi4); end
    checks++; if (ir4 !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got=%0b want=0", ir4); end
    checks++; if (ov6 !== 1'b0 || ov8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid_nb68 got=%0b%0b want=00", ov6, ov8); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%0b want=1", ir4); end
  endtask

  task automatic test_forward_nb4();
    @(negedge clk);
    iv4 = 1'b1; ii4 = 1'b0; is4 = AES_IN; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL fwd4_valid got=%0b want=1", ov4); end
    checks++; if (os4 !== AES_OUT) begin failures++; $display("FAIL fwd4_state got=%h want=%h", os4, AES_OUT); end
    checks++; if (oi4 !== 1'b0) begin failures++; $display("FAIL fwd4_inverse got=%0b want=0", oi4); end
  endtask

  task automatic test_inverse_nb4();
    @(negedge clk);
    iv4 = 1'b1; ii4 = 1'b1; is4 = AES_OUT; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL inv4_valid got=%0b want=1", ov4); end
    checks++; if (os4 !== AES_IN) begin failures++; $display("FAIL inv4_state got=%h want=%h", os4, AES_IN); end
    checks++; if (oi4 !== 1'b1) begin failures++; $display("FAIL inv4_inverse got=%0b want=1", oi4); end
  endtask

  task automatic test_nb8();
    logic [255:0] fw;
    @(negedge clk);
    iv8 = 1'b1; ii8 = 1'b0; is8 = SEQ32; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    fw = os8;
    checks++; if (ov8 !== 1'b1) begin failures++; $display("FAIL nb8_valid got=%0b want=1", ov8); end
    checks++; if (fw[255:224] !== 32'h00050e13) begin failures++; $display("FAIL nb8_col0 got=%h want=00050e13", fw[255:224]); end
    checks++; if (fw[31:0] !== 32'h1c010a0f) begin failures++; $display("FAIL nb8_col7 got=%h want=1c010a0f", fw[31:0]); end
    @(negedge clk);
    iv8 = 1'b1; ii8 = 1'b1; is8 = fw;
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (os8 !== SEQ32 || oi8 !== 1'b1) begin failures++; $display("FAIL nb8_identity got=%h/%0b want=%h/1", os8, oi8, SEQ32); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v[4];
    logic [127:0] e[4];
    logic [255:0] t;
    logic a, d, cap_i;
    logic [127:0] cap_s;
    int acc, got;
    v[0] = AES_IN;
    v[1] = 128'h00112233445566778899aabbccddeeff;
    v[2] = 128'h0f0e0d0c0b0a09080706050403020100;
    v[3] = 128'h3243f6a8885a308d313198a2e0370734;
    for (int k = 0; k < 4; k++) begin
      t = ref_shift(4, {128'b0, v[k]}, k[0]);
      e[k] = t[127:0];
    end
    acc = 0; got = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      or4 = 1'b0; iv4 = 1'b1; is4 = v[acc]; ii4 = acc[0];
      a = ir4;
      @(posedge clk);
      if (a) acc++;
    end
    @(negedge clk);
    checks++; if (acc !== 2) begin failures++; $display("FAIL b2b_accepted got=%0d want=2", acc); end
    checks++; if (ir4 !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready got=%0b want=0", ir4); end
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      or4 = 1'b1;
      if (acc < 4) begin iv4 = 1'b1; is4 = v[acc]; ii4 = acc[0]; end
      else iv4 = 1'b0;
      a = iv4 && ir4; d = ov4; cap_s = os4; cap_i = oi4;
      @(posedge clk);
      if (a) acc++;
      if (d) begin
        checks++;
        if (cap_s !== e[got] || cap_i !== got[0]) begin
          failures++; $display("FAIL b2b_order[%0d] got=%h/%0b want=%h/%0b", got, cap_s, cap_i, e[got], got[0]);
        end
        got++;
      end
    end
    @(negedge clk);
    iv4 = 1'b0;
    checks++; if (got !== 4) begin failures++; $display("FAIL b2b_drain_count got=%0d want=4", got); end
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%0b want=1", ir4); end
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL b2b_no_duplicate got=%0b want=0", ov4); end
  endtask

  task automatic test_random_nb6();
    logic [191:0] qs[$];
    logic qi[$];
    logic [255:0] t;
    logic [191:0] pst, es;
    logic a, d, pin, stalled, ei;
    int sent, got, bad_data, bad_hold;
    sent = 0; got = 0; a = 1'b0; stalled = 1'b0; bad_data = 0; bad_hold = 0;
    pst = '0; pin = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (ov6 !== 1'b1 || os6 !== pst || oi6 !== pin) begin
          failures++; bad_hold++;
          if (bad_hold < 5) $display("FAIL rnd_hold got=%0b/%h want=1/%h", ov6, os6, pst);
        end
      end
      if (a) iv6 = 1'b0;
      if (!iv6 && sent < 1000 && $urandom_range(0, 3) != 0) begin
        iv6 = 1'b1;
        is6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ii6 = 1'($urandom_range(0, 1));
      end
      or6 = ($urandom_range(0, 2) != 0);
      a = iv6 && ir6; d = ov6 && or6; stalled = ov6 && !or6; pst = os6; pin = oi6;
      @(posedge clk);
      if (d) begin
        checks++;
        if (qs.size() == 0) begin
          failures++; $display("FAIL rnd_spurious got=%h want=none", pst);
        end else begin
          es = qs.pop_front(); ei = qi.pop_front();
          if (pst !== es || pin !== ei) begin
            failures++; bad_data++;
            if (bad_data < 5) $display("FAIL rnd_data[%0d] got=%h/%0b want=%h/%0b", got, pst, pin, es, ei);
          end
        end
        got++;
      end
      if (a) begin
        t = ref_shift(6, {64'b0, is6}, ii6);
        qs.push_back(t[191:0]); qi.push_back(ii6);
        sent++;
      end
    end
    @(negedge clk);
    iv6 = 1'b0;
    checks++; if (got !== 1000) begin failures++; $display("FAIL rnd_count got=%0d want=1000", got); end
  endtask

  task automatic test_reset_mid();
    logic a;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      or4 = 1'b0; iv4 = 1'b1; ii4 = 1'b0; is4 = (k == 0) ? AES_IN : AES_OUT;
      a = ir4;
      @(posedge clk);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rstmid_fill_ready[%0d] got=%0b want=1", k, a); end
    end
    @(negedge clk);
    checks++; if (ir4 !== 1'b0 || ov4 !== 1'b1) begin failures++; $display("FAIL rstmid_full got=%0b/%0b want=0/1", ir4, ov4); end
    rst = 1'b1; or4 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b want=0", ov4); end
    checks++; if (os4 !== '0) begin failures++; $display("FAIL rstmid_state got=%h want=0", os4); end
    @(negedge clk);
    rst = 1'b0; iv4 = 1'b0;
    #1;
    checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b want=1", ir4); end
    iv4 = 1'b1; ii4 = 1'b0; is4 = AES_IN; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++; if (ov4 !== 1'b1 || os4 !== AES_OUT) begin failures++; $display("FAIL rstmid_first got=%0b/%h want=1/%h", ov4, os4, AES_OUT); end
    @(posedge clk); #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rstmid_no_stale got=%0b want=0", ov4); end
  endtask

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; ii4 = 1'b0; is4 = '0; or4 = 1'b0;
    iv6 = 1'b0; ii6 = 1'b0; is6 = '0; or6 = 1'b0;
    iv8 = 1'b0; ii8 = 1'b0; is8 = '0; or8 = 1'b0;
    test_reset();
    test_forward_nb4();
    test_inverse_nb4();
    test_nb8();
    test_back_to_back();
    test_random_nb6();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
